// File: rtl/grid_overlay.sv
// grid_overlay: draws a COLS x ROWS grid of LINE_T-thick lines over the
// active VGA area and, optionally, a blinking cursor cell.
// Both pixel flags are registered one clock behind the counters.
// Optional feature macro: GRID_OVERLAY_CURSOR_EN builds the cursor,
// the move handshake, the frame counter and the blink logic. Without it
// only the grid remains and the cursor outputs are tied off.
module grid_overlay #(
   parameter int CNT_W        = 16,
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int COLS         = 3,
   parameter int ROWS         = 3,
   parameter int H_START      = 341,
   parameter int H_PITCH      = 240,
   parameter int V_START      = 173,
   parameter int V_PITCH      = 171,
   parameter int LINE_T       = 4,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CNT_W-1:0]          h_count,
   input  logic [CNT_W-1:0]          v_count,
   input  logic                      move_valid,
   input  logic [1:0]                move_dir,
   output logic                      move_ready,
   output logic [$clog2(COLS)-1:0]   cursor_col,
   output logic [$clog2(ROWS)-1:0]   cursor_row,
   output logic                      grid_px,
   output logic                      cursor_px
);

   localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);

   logic on_vline;
   logic on_hline;
   logic active;
   logic grid_px_d;
   logic grid_px_q;

   // Line membership: each line occupies LINE_T pixels from its start position
   always_comb begin
      on_vline = 1'b0;
      on_hline = 1'b0;
      for (int k = 1; k < COLS; k++) begin
         if ((h_count >= CNT_W'(H_START + (k - 1) * H_PITCH)) &&
             (h_count <= CNT_W'(H_START + (k - 1) * H_PITCH + LINE_T - 1)))
            on_vline = 1'b1;
      end
      for (int j = 1; j < ROWS; j++) begin
         if ((v_count >= CNT_W'(V_START + (j - 1) * V_PITCH)) &&
             (v_count <= CNT_W'(V_START + (j - 1) * V_PITCH + LINE_T - 1)))
            on_hline = 1'b1;
      end
      active    = (h_count < H_ACT) && (v_count < V_ACT);
      grid_px_d = active && (on_vline || on_hline);
   end

   // Grid flag register, one pixel behind the counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) grid_px_q <= 1'b0;
      else        grid_px_q <= grid_px_d;
   end

   assign grid_px = grid_px_q;

`ifdef GRID_OVERLAY_CURSOR_EN
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
   localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(BLINK_FRAMES - 1);

   logic [COL_W-1:0] cell_col;
   logic [ROW_W-1:0] cell_row;
   logic             zero_d, zero_q;
   logic             zero_dly_d, zero_dly_q;
   logic             frame_evt;
   logic             pending_d, pending_q;
   logic [1:0]       pend_dir_d, pend_dir_q;
   logic [COL_W-1:0] cursor_col_d, cursor_col_q;
   logic [ROW_W-1:0] cursor_row_d, cursor_row_q;
   logic [FC_W-1:0]  frame_cnt_d, frame_cnt_q;
   logic             blink_on_d, blink_on_q;
   logic             cursor_px_d, cursor_px_q;

   // Cell index = number of lines whose first pixel has been reached
   always_comb begin
      cell_col = '0;
      cell_row = '0;
      for (int k = 1; k < COLS; k++) begin
         if (h_count >= CNT_W'(H_START + (k - 1) * H_PITCH))
            cell_col = cell_col + COL_W'(1);
      end
      for (int j = 1; j < ROWS; j++) begin
         if (v_count >= CNT_W'(V_START + (j - 1) * V_PITCH))
            cell_row = cell_row + ROW_W'(1);
      end
   end

   assign frame_evt = zero_q && !zero_dly_q;

   // Next state: accept moves, commit them at frame start, run the blink timer
   always_comb begin
      zero_d       = (h_count == '0) && (v_count == '0);
      zero_dly_d   = zero_q;
      pending_d    = pending_q;
      pend_dir_d   = pend_dir_q;
      cursor_col_d = cursor_col_q;
      cursor_row_d = cursor_row_q;
      frame_cnt_d  = frame_cnt_q;
      blink_on_d   = blink_on_q;

      if (frame_evt && pending_q) begin
         pending_d   = 1'b0;
         frame_cnt_d = '0;
         blink_on_d  = 1'b1;
         case (pend_dir_q)
            2'b00:   cursor_row_d = (cursor_row_q == '0) ? ROW_MAX : cursor_row_q - ROW_W'(1);
            2'b01:   cursor_row_d = (cursor_row_q == ROW_MAX) ? '0 : cursor_row_q + ROW_W'(1);
            2'b10:   cursor_col_d = (cursor_col_q == '0) ? COL_MAX : cursor_col_q - COL_W'(1);
            default: cursor_col_d = (cursor_col_q == COL_MAX) ? '0 : cursor_col_q + COL_W'(1);
         endcase
      end else if (frame_evt) begin
         if (frame_cnt_q == FC_MAX) begin
            frame_cnt_d = '0;
            blink_on_d  = !blink_on_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
         end
      end

      if (move_valid && !pending_q) begin
         pending_d  = 1'b1;
         pend_dir_d = move_dir;
      end

      cursor_px_d = active && !on_vline && !on_hline && blink_on_q &&
                    (cell_col == cursor_col_q) && (cell_row == cursor_row_q);
   end

   // Cursor state registers; reset drops any pending move
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q       <= 1'b0;
         zero_dly_q   <= 1'b0;
         pending_q    <= 1'b0;
         pend_dir_q   <= 2'b00;
         cursor_col_q <= '0;
         cursor_row_q <= '0;
         frame_cnt_q  <= '0;
         blink_on_q   <= 1'b1;
         cursor_px_q  <= 1'b0;
      end else begin
         zero_q       <= zero_d;
         zero_dly_q   <= zero_dly_d;
         pending_q    <= pending_d;
         pend_dir_q   <= pend_dir_d;
         cursor_col_q <= cursor_col_d;
         cursor_row_q <= cursor_row_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_on_q   <= blink_on_d;
         cursor_px_q  <= cursor_px_d;
      end
   end

   assign move_ready = !pending_q;
   assign cursor_col = cursor_col_q;
   assign cursor_row = cursor_row_q;
   assign cursor_px  = cursor_px_q;
`else
   logic unused_move;
   assign unused_move = ^{move_valid, move_dir};

   assign move_ready = 1'b1;
   assign cursor_col = '0;
   assign cursor_row = '0;
   assign cursor_px  = 1'b0;
`endif

endmodule
